// File: rtl/pixel_threshold_engine.sv
// pixel_threshold_engine: per-lane stream thresholder with programmable mode and thresholds.
// The input beat is split into PIX_WIDTH lanes. Each lane is binarised, band-passed,
// clipped or bypassed. Results go to a 2-entry output buffer that absorbs downstream
// backpressure. Hit/beat counters and a frame-complete interrupt are also kept here.
// Ports:
//   i_user_clk, i_rst_n           clock, async active-low reset
//   i_user_*/o_user_*             register write/read interface (addr[4:2] = word index)
//   i_str_data_valid/i_str_data   input beat; o_str_ack = input ready
//   o_str_data_valid/o_str_data   output beat; i_str_ack = downstream ready
//   o_intr_req/i_intr_ack         frame-complete interrupt handshake
module pixel_threshold_engine #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned DEFAULT_TH = 118
) (
    input  logic                  i_user_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_user_data,
    input  logic [19:0]           i_user_addr,
    input  logic                  i_user_wr_req,
    input  logic                  i_user_rd_req,
    output logic [31:0]           o_user_data,
    output logic                  o_user_rd_ack,
    input  logic                  i_str_data_valid,
    input  logic [DATA_WIDTH-1:0] i_str_data,
    output logic                  o_str_ack,
    output logic                  o_str_data_valid,
    output logic [DATA_WIDTH-1:0] o_str_data,
    input  logic                  i_str_ack,
    output logic                  o_intr_req,
    input  logic                  i_intr_ack
);

    localparam int unsigned LANES = DATA_WIDTH / PIX_WIDTH;

    // Configuration and statistics registers
    logic [1:0]           mode;
    logic [PIX_WIDTH-1:0] th_lo;
    logic [PIX_WIDTH-1:0] th_hi;
    logic [31:0]          hit_cnt;
    logic [31:0]          beat_cnt;
    logic [31:0]          frame_beats;

    // Output buffer state
    logic [1:0][DATA_WIDTH-1:0] fifo_mem;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 count;

    logic [2:0] wr_idx;
    logic       reg_wr;
    logic       clr;
    logic       accept;
    logic       pop;

    logic [LANES-1:0][PIX_WIDTH-1:0] pix;
    logic [LANES-1:0][PIX_WIDTH-1:0] res;
    logic [LANES-1:0]                hit_vec;
    logic [31:0]                     hit_sum;
    logic [32:0]                     hit_add;
    logic [31:0]                     hit_next;
    logic [31:0]                     beat_next;
    logic                            intr_set;
    logic [31:0]                     rd_mux;

    // Address bits outside the decoded word index are intentionally ignored
    logic addr_unused;
    assign addr_unused = ^{i_user_addr[19:5], i_user_addr[1:0]};

    assign wr_idx = i_user_addr[4:2];
    assign reg_wr = i_user_wr_req;
    assign clr    = reg_wr && (wr_idx == 3'd0) && i_user_data[2];

    assign o_str_ack        = (count < 2'd2);
    assign o_str_data_valid = (count != 2'd0);
    assign o_str_data       = fifo_mem[rd_ptr];

    assign accept = i_str_data_valid && o_str_ack;
    assign pop    = o_str_data_valid && i_str_ack;

    assign pix = i_str_data;

    // Per-lane transform and hit detection, using the configuration as it stands this cycle
    always_comb begin
        res     = '0;
        hit_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            case (mode)
                2'd0:    res[i] = (pix[i] >= th_lo) ? '1 : '0;
                2'd1:    res[i] = ((pix[i] >= th_lo) && (pix[i] <= th_hi)) ? '1 : '0;
                2'd2:    res[i] = (pix[i] >= th_lo) ? pix[i] : '0;
                default: res[i] = pix[i];
            endcase
            hit_vec[i] = (mode == 2'd3) ? (pix[i] >= th_lo) : (res[i] != '0);
        end
    end

    // Hit popcount and saturating counter updates
    always_comb begin
        hit_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_sum = hit_sum + 32'(hit_vec[i]);
        end
        hit_add   = {1'b0, hit_cnt} + 33'(hit_sum);
        hit_next  = hit_add[32] ? '1 : hit_add[31:0];
        beat_next = (beat_cnt == 32'hFFFF_FFFF) ? beat_cnt : beat_cnt + 32'd1;
        intr_set  = accept && !clr && (frame_beats != 32'd0) && (beat_next == frame_beats);
    end

    // Register read mux; thresholds zero-extend
    always_comb begin
        rd_mux = '0;
        case (i_user_addr[4:2])
            3'd0:    rd_mux = {30'd0, mode};
            3'd1:    rd_mux = 32'(th_lo);
            3'd2:    rd_mux = 32'(th_hi);
            3'd3:    rd_mux = hit_cnt;
            3'd4:    rd_mux = beat_cnt;
            3'd5:    rd_mux = frame_beats;
            default: rd_mux = '0;
        endcase
    end

    // Configuration registers and register read port
    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode          <= '0;
            th_lo         <= PIX_WIDTH'(DEFAULT_TH);
            th_hi         <= '1;
            frame_beats   <= '0;
            o_user_rd_ack <= 1'b0;
            o_user_data   <= '0;
        end else begin
            o_user_rd_ack <= i_user_rd_req;
            if (i_user_rd_req) begin
                o_user_data <= rd_mux;
            end
            if (reg_wr) begin
                case (wr_idx)
                    3'd0:    mode        <= i_user_data[1:0];
                    3'd1:    th_lo       <= i_user_data[PIX_WIDTH-1:0];
                    3'd2:    th_hi       <= i_user_data[PIX_WIDTH-1:0];
                    3'd5:    frame_beats <= i_user_data;
                    default: ;
                endcase
            end
        end
    end

    // Statistics counters and interrupt; a clear beats a coincident accept
    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt    <= '0;
            beat_cnt   <= '0;
            o_intr_req <= 1'b0;
        end else begin
            if (clr) begin
                hit_cnt  <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                hit_cnt  <= hit_next;
                beat_cnt <= beat_next;
            end
            if (intr_set) begin
                o_intr_req <= 1'b1;
            end else if (i_intr_ack) begin
                o_intr_req <= 1'b0;
            end
        end
    end

    // Two-entry output buffer; the head slot is never overwritten while occupied
    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_mem <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= res;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_threshold_engine.sv
// Directed self-checking bench for pixel_threshold_engine.
module tb_pixel_threshold_engine;

    logic        clk;
    logic        rst_n;
    logic [31:0] user_wdata;
    logic [19:0] user_addr;
    logic        user_wr_req;
    logic        user_rd_req;
    logic [31:0] user_rdata;
    logic        user_rd_ack;
    logic        str_in_valid;
    logic [63:0] str_in_data;
    logic        str_in_ack;
    logic        str_out_valid;
    logic [63:0] str_out_data;
    logic        str_out_ack;
    logic        intr_req;
    logic        intr_ack;

    int n_checks;
    int n_errors;

    pixel_threshold_engine #(
        .DATA_WIDTH(64),
        .PIX_WIDTH (8),
        .DEFAULT_TH(118)
    ) dut (
        .i_user_clk      (clk),
        .i_rst_n         (rst_n),
        .i_user_data     (user_wdata),
        .i_user_addr     (user_addr),
        .i_user_wr_req   (user_wr_req),
        .i_user_rd_req   (user_rd_req),
        .o_user_data     (user_rdata),
        .o_user_rd_ack   (user_rd_ack),
        .i_str_data_valid(str_in_valid),
        .i_str_data      (str_in_data),
        .o_str_ack       (str_in_ack),
        .o_str_data_valid(str_out_valid),
        .o_str_data      (str_out_data),
        .i_str_ack       (str_out_ack),
        .o_intr_req      (intr_req),
        .i_intr_ack      (intr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] idx, input logic [31:0] data);
        user_addr   = {15'd0, idx, 2'b00};
        user_wdata  = data;
        user_wr_req = 1'b1;
        tick();
        user_wr_req = 1'b0;
    endtask

    task automatic reg_read_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        user_addr   = {15'd0, idx, 2'b00};
        user_rd_req = 1'b1;
        tick();
        user_rd_req = 1'b0;
        check({tag, "_ack"}, 64'(user_rd_ack), 64'd1);
        check(tag, 64'(user_rdata), 64'(exp));
    endtask

    // Send one beat into an empty buffer with downstream ready, check the result, drain it
    task automatic beat_check(input string tag, input logic [63:0] din, input logic [63:0] exp);
        str_in_data  = din;
        str_in_valid = 1'b1;
        tick();
        str_in_valid = 1'b0;
        check({tag, "_valid"}, 64'(str_out_valid), 64'd1);
        check(tag, str_out_data, exp);
        tick();
    endtask

    localparam logic [63:0] B1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] B3 = 64'h9999_AAAA_BBBB_CCCC;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        user_wdata   = '0;
        user_addr    = '0;
        user_wr_req  = 1'b0;
        user_rd_req  = 1'b0;
        str_in_valid = 1'b0;
        str_in_data  = '0;
        str_out_ack  = 1'b1;
        intr_ack     = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ack", 64'(str_in_ack), 64'd1);
        check("rst_out_valid", 64'(str_out_valid), 64'd0);
        check("rst_out_data", str_out_data, 64'd0);
        check("rst_intr", 64'(intr_req), 64'd0);
        check("rst_rd_ack", 64'(user_rd_ack), 64'd0);
        reg_read_check("rst_ctrl", 3'd0, 32'd0);
        reg_read_check("rst_th_lo", 3'd1, 32'd118);
        reg_read_check("rst_th_hi", 3'd2, 32'd255);
        reg_read_check("rst_frame", 3'd5, 32'd0);

        // MODE0 with default threshold 0x76
        beat_check("m0", 64'h0075_7677_FF80_0100, 64'h0000_FFFF_FFFF_0000);
        reg_read_check("m0_hit", 3'd3, 32'd4);
        reg_read_check("m0_beat", 3'd4, 32'd1);

        // MODE1 band pass
        reg_write(3'd0, 32'd1);
        reg_write(3'd1, 32'h40);
        reg_write(3'd2, 32'h80);
        beat_check("m1", 64'h3F40_8081_6000_FF7F, 64'h00FF_FF00_FF00_00FF);
        reg_write(3'd2, 32'h10);
        beat_check("m1_empty", 64'h4050_6070_8090_A0FF, 64'h0);

        // MODE2 clip
        reg_write(3'd0, 32'd2);
        reg_write(3'd1, 32'h10);
        beat_check("m2", 64'h0F10_AA00_1105_FF20, 64'h0010_AA00_1100_FF20);

        // MODE3 bypass
        reg_write(3'd0, 32'd3);
        beat_check("m3", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        reg_read_check("acc_hit", 3'd3, 32'd20);
        reg_read_check("acc_beat", 3'd4, 32'd5);

        // Threshold width truncation and unmapped read
        reg_write(3'd2, 32'h0000_12C4);
        reg_read_check("th_hi_trunc", 3'd2, 32'hC4);
        reg_read_check("unmapped", 3'd6, 32'd0);

        // Backpressure in bypass mode
        str_out_ack  = 1'b0;
        str_in_valid = 1'b1;
        str_in_data  = B1;
        check("bp_ack0", 64'(str_in_ack), 64'd1);
        tick();
        str_in_data = B2;
        check("bp_ack1", 64'(str_in_ack), 64'd1);
        tick();
        str_in_data = B3;
        check("bp_full", 64'(str_in_ack), 64'd0);
        check("bp_head0", str_out_data, B1);
        tick();
        check("bp_hold_valid", 64'(str_out_valid), 64'd1);
        check("bp_hold", str_out_data, B1);
        tick();
        check("bp_hold2", str_out_data, B1);
        check("bp_still_full", 64'(str_in_ack), 64'd0);
        str_out_ack = 1'b1;
        tick();
        check("bp_out2", str_out_data, B2);
        check("bp_ack_back", 64'(str_in_ack), 64'd1);
        tick();
        str_in_valid = 1'b0;
        check("bp_out3", str_out_data, B3);
        check("bp_out3_valid", 64'(str_out_valid), 64'd1);
        tick();
        check("bp_empty", 64'(str_out_valid), 64'd0);
        reg_read_check("bp_beat", 3'd4, 32'd8);

        // Frame interrupt: clear, then four beats
        reg_write(3'd0, 32'h7);
        reg_read_check("clr_beat", 3'd4, 32'd0);
        reg_write(3'd5, 32'd4);
        for (int i = 0; i < 3; i++) begin
            beat_check("fr_beat", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        check("fr_intr_early", 64'(intr_req), 64'd0);
        beat_check("fr_beat4", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("fr_intr_set", 64'(intr_req), 64'd1);
        tick();
        tick();
        check("fr_intr_hold", 64'(intr_req), 64'd1);
        reg_read_check("fr_hit", 3'd3, 32'd32);
        reg_read_check("fr_beat_cnt", 3'd4, 32'd4);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        check("fr_intr_clr", 64'(intr_req), 64'd0);

        // Clear via CTRL=0x4
        reg_write(3'd0, 32'h4);
        reg_read_check("clr_hit", 3'd3, 32'd0);
        reg_read_check("clr_beat2", 3'd4, 32'd0);

        // Clear coinciding with an accept drops that beat's contribution
        str_in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        str_in_valid = 1'b1;
        user_addr    = 20'h0;
        user_wdata   = 32'h4;
        user_wr_req  = 1'b1;
        tick();
        str_in_valid = 1'b0;
        user_wr_req  = 1'b0;
        tick();
        reg_read_check("clr_acc_beat", 3'd4, 32'd0);
        reg_read_check("clr_acc_hit", 3'd3, 32'd0);
        check("clr_acc_intr", 64'(intr_req), 64'd0);

        // Reset with the buffer full
        reg_write(3'd1, 32'h20);
        str_out_ack  = 1'b0;
        str_in_valid = 1'b1;
        str_in_data  = B1;
        tick();
        tick();
        str_in_valid = 1'b0;
        check("rr_full", 64'(str_in_ack), 64'd0);
        check("rr_valid_pre", 64'(str_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_valid", 64'(str_out_valid), 64'd0);
        check("rr_data", str_out_data, 64'd0);
        #3;
        rst_n = 1'b1;
        str_out_ack = 1'b1;
        tick();
        check("rr_in_ack", 64'(str_in_ack), 64'd1);
        check("rr_valid_post", 64'(str_out_valid), 64'd0);
        reg_read_check("rr_th_lo", 3'd1, 32'd118);
        reg_read_check("rr_frame", 3'd5, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
